trace_buffer: RTL and testbench

Synthesisable retirement-trace capture buffer for the CPU core. It generalises the testbench's PC/register-file monitoring into hardware. It sits beside the controller and snoops each committed instruction (PC plus register writeback) into a parametrised circular buffer. Capture freezes a programmable number of commits after a PC-match trigger, and the frozen window is then drained through a valid/ready readout port.

---
 rtl/trace_pkg.sv | 18 +
 rtl/trace_mem.sv | 28 ++
 rtl/trace_buffer.sv | 191 +++++++++++++++++++
 tb/tb_trace_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the retirement-trace capture buffer: FSM state
// encoding and the width of one stored trace entry.
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_POST    = 3'd2,
    ST_FROZEN  = 3'd3,
    ST_READOUT = 3'd4
  } trace_state_e;

  // One entry packs {pc, rd, we, wdata}.
  function automatic int entry_width(input int pc_w, input int reg_w, input int data_w);
    return pc_w + reg_w + 1 + data_w;
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Trace storage: flop array with one synchronous write port and one
// combinational read port. Data is deliberately not reset; only the
// pointers and counters in the controller define which entries are valid.
module trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 70,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write the captured entry at the controller's write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Retirement-trace capture buffer. Snoops committed instructions into a
// circular buffer, freezes a programmable number of commits after a PC-match
// trigger, then drains the frozen window oldest-first over valid/ready.
module trace_buffer
  import trace_pkg::*;
#(
  parameter int PC_WIDTH       = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 16,
  parameter int POST_TRIG      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       commit_valid,
  input  logic [PC_WIDTH-1:0]        commit_pc,
  input  logic [REG_ADDR_WIDTH-1:0]  commit_rd,
  input  logic                       commit_we,
  input  logic [DATA_WIDTH-1:0]      commit_wdata,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [PC_WIDTH-1:0]        trig_pc,
  input  logic                       rd_start,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [PC_WIDTH-1:0]        rd_pc,
  output logic [REG_ADDR_WIDTH-1:0]  rd_rd,
  output logic                       rd_we,
  output logic [DATA_WIDTH-1:0]      rd_wdata,
  output logic                       rd_last,
  output logic [2:0]                 state_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = entry_width(PC_WIDTH, REG_ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] POST_LD = CW'(POST_TRIG);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);

  trace_state_e        state_r,    state_s;
  logic [AW-1:0]       wr_ptr_r,   wr_ptr_s;
  logic [AW-1:0]       rd_ptr_r,   rd_ptr_s;
  logic [CW-1:0]       count_r,    count_s;
  logic [CW-1:0]       post_cnt_r, post_cnt_s;
  logic [CW-1:0]       remain_r,   remain_s;
  logic                wr_en_s;
  logic                trig_hit_s;
  logic [ENTRY_W-1:0]  wr_entry_s;
  logic [ENTRY_W-1:0]  rd_entry_s;

  assign trig_hit_s = trig_en && (commit_pc == trig_pc);
  assign wr_entry_s = {commit_pc, commit_rd, commit_we, commit_wdata};

  trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (wr_entry_s),
    .raddr (rd_ptr_r),
    .rdata (rd_entry_s)
  );

  // Next-state, pointer and counter logic; arm overrides everything.
  always_comb begin
    state_s    = state_r;
    wr_ptr_s   = wr_ptr_r;
    rd_ptr_s   = rd_ptr_r;
    count_s    = count_r;
    post_cnt_s = post_cnt_r;
    remain_s   = remain_r;
    wr_en_s    = 1'b0;
    if (arm) begin
      state_s    = ST_PRE;
      wr_ptr_s   = {AW{1'b0}};
      count_s    = {CW{1'b0}};
      post_cnt_s = {CW{1'b0}};
      remain_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_PRE, ST_POST: begin
          if (commit_valid) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + ONE_P;
            // Saturating count: once full, each write overwrites the oldest.
            if (count_r != FULL) begin
              count_s = count_r + ONE_C;
            end else begin
              count_s = count_r;
            end
            if (state_r == ST_PRE) begin
              if (trig_hit_s) begin
                if (POST_TRIG == 0) begin
                  state_s = ST_FROZEN;
                end else begin
                  state_s    = ST_POST;
                  post_cnt_s = POST_LD;
                end
              end else begin
                state_s = ST_PRE;
              end
            end else begin
              post_cnt_s = post_cnt_r - ONE_C;
              if (post_cnt_r == ONE_C) begin
                state_s = ST_FROZEN;
              end else begin
                state_s = ST_POST;
              end
            end
          end else begin
            state_s = state_r;
          end
        end
        ST_FROZEN: begin
          if (rd_start) begin
            // Oldest entry sits at wr_ptr once the buffer has wrapped.
            if (count_r == FULL) begin
              rd_ptr_s = wr_ptr_r;
            end else begin
              rd_ptr_s = {AW{1'b0}};
            end
            remain_s = count_r;
            if (count_r == {CW{1'b0}}) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_READOUT;
            end
          end else begin
            state_s = ST_FROZEN;
          end
        end
        ST_READOUT: begin
          if (rd_ready) begin
            rd_ptr_s = rd_ptr_r + ONE_P;
            remain_s = remain_r - ONE_C;
            if (remain_r == ONE_C) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_READOUT;
            end
          end else begin
            state_s = ST_READOUT;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      post_cnt_r <= {CW{1'b0}};
      remain_r   <= {CW{1'b0}};
    end else begin
      state_r    <= state_s;
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      count_r    <= count_s;
      post_cnt_r <= post_cnt_s;
      remain_r   <= remain_s;
    end
  end

  // Readout fields are forced to zero when not valid so reset and idle
  // never expose undefined memory contents.
  assign rd_valid = (state_r == ST_READOUT);
  assign rd_last  = rd_valid && (remain_r == ONE_C);
  assign rd_pc    = rd_valid ? rd_entry_s[ENTRY_W-1 -: PC_WIDTH] : {PC_WIDTH{1'b0}};
  assign rd_rd    = rd_valid ? rd_entry_s[DATA_WIDTH+1 +: REG_ADDR_WIDTH] : {REG_ADDR_WIDTH{1'b0}};
  assign rd_we    = rd_valid ? rd_entry_s[DATA_WIDTH] : 1'b0;
  assign rd_wdata = rd_valid ? rd_entry_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign state_o  = state_r;
  assign count_o  = count_r;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: two instances (POST_TRIG=8 and POST_TRIG=0) share
// stimulus; each is checked every cycle against a queue-based model, and
// directed scenarios pin the model with hand-computed values.
module tb_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = 32'd0;
  logic [4:0]  commit_rd = 5'd0;
  logic        commit_we = 1'b0;
  logic [31:0] commit_wdata = 32'd0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = 32'd0;
  logic        rd_start = 1'b0;
  logic        rd_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
  } entry_t;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int PT = (g == 0) ? 8 : 0;
    logic        rd_valid, rd_we, rd_last;
    logic [31:0] rd_pc, rd_wdata;
    logic [4:0]  rd_rd;
    logic [2:0]  state_o;
    logic [4:0]  count_o;

    trace_buffer #(
      .PC_WIDTH(32), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5),
      .DEPTH(DEPTH), .POST_TRIG(PT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_rd(commit_rd),
      .commit_we(commit_we), .commit_wdata(commit_wdata),
      .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
      .rd_start(rd_start), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_rd(rd_rd), .rd_we(rd_we),
      .rd_wdata(rd_wdata), .rd_last(rd_last),
      .state_o(state_o), .count_o(count_o)
    );

    // Model: state code, commits left after trigger, capture queue
    // (oldest first, at most DEPTH), and the queue being drained.
    int     m_st = 0;
    int     m_post = 0;
    entry_t m_q[$];
    entry_t m_rq[$];
    entry_t e;

    always begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = 0; m_post = 0; m_q.delete(); m_rq.delete();
      end else if (arm) begin
        m_st = 1; m_post = 0; m_q.delete(); m_rq.delete();
      end else if ((m_st == 1 || m_st == 2) && commit_valid) begin
        e.pc = commit_pc; e.rd = commit_rd; e.we = commit_we; e.wdata = commit_wdata;
        m_q.push_back(e);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
        if (m_st == 1) begin
          if (trig_en && commit_pc == trig_pc) begin
            if (PT == 0) m_st = 3;
            else begin m_st = 2; m_post = PT; end
          end
        end else begin
          m_post--;
          if (m_post == 0) m_st = 3;
        end
      end else if (m_st == 3 && rd_start) begin
        m_rq = m_q;
        m_st = (m_rq.size() == 0) ? 0 : 4;
      end else if (m_st == 4 && rd_ready) begin
        void'(m_rq.pop_front());
        if (m_rq.size() == 0) m_st = 0;
      end
    end

    // Compare on the falling edge, away from the active edge.
    always begin
      @(negedge clk);
      check($sformatf("u%0d state", g), 64'(state_o), 64'(m_st));
      check($sformatf("u%0d count", g), 64'(count_o), 64'(m_q.size()));
      check($sformatf("u%0d rd_valid", g), 64'(rd_valid), 64'(m_st == 4));
      check($sformatf("u%0d rd_last", g), 64'(rd_last), 64'(m_st == 4 && m_rq.size() == 1));
      if (m_st == 4) begin
        check($sformatf("u%0d rd_pc", g), 64'(rd_pc), 64'(m_rq[0].pc));
        check($sformatf("u%0d rd_rd", g), 64'(rd_rd), 64'(m_rq[0].rd));
        check($sformatf("u%0d rd_we", g), 64'(rd_we), 64'(m_rq[0].we));
        check($sformatf("u%0d rd_wdata", g), 64'(rd_wdata), 64'(m_rq[0].wdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit(input logic [31:0] pc);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_rd    = 5'($urandom);
    commit_we    = 1'($urandom);
    commit_wdata = $urandom;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_start();
    rd_start = 1'b1; tick(); rd_start = 1'b0;
  endtask

  // Drain instance 0 with rd_ready high, expecting an arithmetic PC sequence.
  task automatic drain(input int want, input logic [31:0] first_pc, input string tag);
    int k = 0;
    rd_ready = 1'b1;
    pulse_start();
    while (gen_dut[0].state_o == 3'd4 && k < DEPTH + 4) begin
      check({tag, " pc"}, 64'(gen_dut[0].rd_pc), 64'(first_pc + 32'(4 * k)));
      check({tag, " last"}, 64'(gen_dut[0].rd_last), 64'(k == want - 1));
      tick();
      k++;
    end
    check({tag, " entries"}, 64'(k), 64'(want));
    check({tag, " idle"}, 64'(gen_dut[0].state_o), 64'd0);
  endtask

  initial begin
    logic [31:0] pc_r;
    int n;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 64'(gen_dut[0].state_o), 64'd0);
    check("reset count", 64'(gen_dut[0].count_o), 64'd0);
    check("reset valid", 64'(gen_dut[0].rd_valid), 64'd0);
    check("reset pc", 64'(gen_dut[0].rd_pc), 64'd0);
    rst_n = 1'b1;
    trig_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_start = 1'($urandom);
      do_commit(32'(4 * i));
    end
    rd_start = 1'b0;
    check("idle state", 64'(gen_dut[0].state_o), 64'd0);
    check("idle count", 64'(gen_dut[0].count_o), 64'd0);
    check("idle valid", 64'(gen_dut[0].rd_valid), 64'd0);

    // Basic window: trigger at 0x14, 8 post-trigger commits.
    trig_pc = 32'h14;
    pulse_arm();
    for (int i = 0; i < 16; i++) do_commit(32'(4 * i));
    check("basic state", 64'(gen_dut[0].state_o), 64'd3);
    check("basic count", 64'(gen_dut[0].count_o), 64'd14);
    check("basic pt0 count", 64'(gen_dut[1].count_o), 64'd6);
    drain(14, 32'h0, "basic");

    // Wrap and overwrite: trigger at i=35, freeze at i=43.
    trig_pc = 32'h8C;
    pulse_arm();
    for (int i = 0; i < 48; i++) do_commit(32'(4 * i));
    check("wrap state", 64'(gen_dut[0].state_o), 64'd3);
    check("wrap count", 64'(gen_dut[0].count_o), 64'd16);
    drain(16, 32'h70, "wrap");

    // Backpressure: rd_ready alternates 0/1 from the first valid cycle.
    trig_pc = 32'h100;
    pulse_arm();
    for (int i = 0; i < 14; i++) begin
      pc_r = $urandom;
      pc_r[1:0] = 2'b01;
      do_commit((i == 3) ? 32'h100 : pc_r);
    end
    check("bp count", 64'(gen_dut[0].count_o), 64'd12);
    check("bp pt0 count", 64'(gen_dut[1].count_o), 64'd4);
    pulse_start();
    n = 0;
    while (gen_dut[0].state_o == 3'd4 && n < 100) begin
      rd_ready = n[0];
      tick();
      n++;
    end
    check("bp drain cycles", 64'(n), 64'd24);
    rd_ready = 1'b1;

    // POST_TRIG=0 with the trigger on the first commit.
    trig_pc = 32'h200;
    pulse_arm();
    do_commit(32'h200);
    check("pt0 state", 64'(gen_dut[1].state_o), 64'd3);
    check("pt0 count", 64'(gen_dut[1].count_o), 64'd1);
    check("pt8 state", 64'(gen_dut[0].state_o), 64'd2);
    pulse_start();
    check("pt0 valid", 64'(gen_dut[1].rd_valid), 64'd1);
    check("pt0 last", 64'(gen_dut[1].rd_last), 64'd1);
    check("pt0 pc", 64'(gen_dut[1].rd_pc), 64'h200);
    tick();
    check("pt0 idle", 64'(gen_dut[1].state_o), 64'd0);
    check("pt0 valid off", 64'(gen_dut[1].rd_valid), 64'd0);

    // Abort readout with arm.
    for (int i = 0; i < 8; i++) do_commit(32'h300 + 32'(4 * i));
    check("abort frozen", 64'(gen_dut[0].count_o), 64'd9);
    pulse_start();
    tick();
    tick();
    pulse_arm();
    check("abort valid", 64'(gen_dut[0].rd_valid), 64'd0);
    check("abort state", 64'(gen_dut[0].state_o), 64'd1);
    check("abort count", 64'(gen_dut[0].count_o), 64'd0);

    // Asynchronous reset in POST.
    trig_pc = 32'h400;
    do_commit(32'h400);
    do_commit(32'h404);
    check("post state", 64'(gen_dut[0].state_o), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async rst state", 64'(gen_dut[0].state_o), 64'd0);
    check("async rst count", 64'(gen_dut[0].count_o), 64'd0);
    check("async rst valid", 64'(gen_dut[1].rd_valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic over a small PC set so triggers occur often.
    for (int c = 0; c < 3000; c++) begin
      arm          = ($urandom_range(0, 99) < 3);
      if (arm) trig_pc = 32'(4 * $urandom_range(0, 15));
      trig_en      = ($urandom_range(0, 9) != 0);
      commit_valid = ($urandom_range(0, 9) < 7);
      commit_pc    = 32'(4 * $urandom_range(0, 15));
      commit_rd    = 5'($urandom);
      commit_we    = 1'($urandom);
      commit_wdata = $urandom;
      rd_start     = ($urandom_range(0, 9) == 0);
      rd_ready     = ($urandom_range(0, 9) < 6);
      tick();
    end
    arm = 1'b0; commit_valid = 1'b0; rd_start = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
